cache_bus_responder: RTL

Memory-side responder for the cache line bus protocol: services line fills (CacheBusRW[1]) and line writebacks (CacheBusRW[0]) issued by an I$ or D$. It stores lines in an internal word array and streams one beat per cycle after a programmable initial latency. During writeback it drives BeatCount/SelBusBeat so the cache presents the matching word. It terminates every accepted burst with a one-cycle CacheBusAck. It sits between a cache instance and the testbench/boot memory, replacing the AHB path for cache-only simulation and FPGA bring-up.

---
 rtl/cache_bus_responder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/cache_bus_responder.sv
// Memory-side responder for the cache line bus: services line fills and writebacks
// from a local beat-organised array, with a programmable initial latency.
module cache_bus_responder #(
    parameter int unsigned PA_BITS  = 32,
    parameter int unsigned LINELEN  = 512,
    parameter int unsigned BEATW    = 64,
    parameter int unsigned MEMLINES = 128,
    parameter int unsigned LATENCY  = 2,
    localparam int unsigned BEATS   = LINELEN / BEATW,
    localparam int unsigned LOGBWPL = $clog2(BEATS)
) (
    input  logic                 i_clk,
    input  logic                 i_resetn,
    input  logic [1:0]           i_cache_bus_rw,
    input  logic [PA_BITS-1:0]   i_cache_bus_adr,
    input  logic [BEATW-1:0]     i_write_beat_data,
    output logic [LOGBWPL-1:0]   o_beat_count,
    output logic                 o_sel_bus_beat,
    output logic [LINELEN-1:0]   o_fetch_buffer,
    output logic                 o_cache_bus_ack,
    output logic                 o_bus_busy,
    output logic                 o_prot_err
);

    localparam int unsigned LOGML = $clog2(MEMLINES);
    localparam int unsigned OFF   = $clog2(LINELEN / 8);

    typedef enum logic [2:0] {StIdle, StWait, StFill, StWb, StDone} state_e;

    state_e               r_state, w_state_d;
    logic [LOGBWPL-1:0]   r_beat_count, w_beat_count_d;
    logic [3:0]           r_wait_cnt, w_wait_cnt_d;
    logic [LOGML-1:0]     r_line_idx, w_line_idx_d;
    logic                 r_is_fill, w_is_fill_d;
    logic                 r_prot_err, w_prot_err_d;
    logic [LINELEN-1:0]   r_fetch_buffer;
    logic                 w_ack;
    logic [BEATW-1:0]     r_mem [MEMLINES*BEATS];
    logic [LOGML+LOGBWPL-1:0] w_mem_idx;
    logic                 w_unused_adr;

    // Upper address bits alias; byte offset within the line is always zero.
    assign w_unused_adr = ^{i_cache_bus_adr[PA_BITS-1:OFF+LOGML], i_cache_bus_adr[OFF-1:0]};
    assign w_mem_idx    = {r_line_idx, r_beat_count};

    always_comb begin
        w_state_d      = r_state;
        w_beat_count_d = r_beat_count;
        w_wait_cnt_d   = r_wait_cnt;
        w_line_idx_d   = r_line_idx;
        w_is_fill_d    = r_is_fill;
        w_prot_err_d   = r_prot_err;
        w_ack          = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_cache_bus_rw == 2'b10 || i_cache_bus_rw == 2'b01) begin
                    w_line_idx_d   = i_cache_bus_adr[OFF+LOGML-1:OFF];
                    w_is_fill_d    = i_cache_bus_rw[1];
                    w_beat_count_d = '0;
                    if (LATENCY > 0) begin
                        w_state_d    = StWait;
                        w_wait_cnt_d = 4'(LATENCY - 1);
                    end else begin
                        w_state_d = i_cache_bus_rw[1] ? StFill : StWb;
                    end
                end else if (i_cache_bus_rw == 2'b11) begin
                    w_prot_err_d = 1'b1;
                end
            end
            StWait: begin
                if (r_wait_cnt == '0) begin
                    w_state_d      = r_is_fill ? StFill : StWb;
                    w_beat_count_d = '0;
                end else begin
                    w_wait_cnt_d = r_wait_cnt - 4'd1;
                end
            end
            StFill, StWb: begin
                w_beat_count_d = r_beat_count + LOGBWPL'(1);
                if (r_beat_count == LOGBWPL'(BEATS - 1)) begin
                    w_ack     = 1'b1;
                    w_state_d = StDone;
                end
            end
            StDone: begin
                w_beat_count_d = '0;
                w_state_d      = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state        <= StIdle;
            r_beat_count   <= '0;
            r_wait_cnt     <= '0;
            r_line_idx     <= '0;
            r_is_fill      <= 1'b0;
            r_prot_err     <= 1'b0;
            r_fetch_buffer <= '0;
        end else begin
            r_state      <= w_state_d;
            r_beat_count <= w_beat_count_d;
            r_wait_cnt   <= w_wait_cnt_d;
            r_line_idx   <= w_line_idx_d;
            r_is_fill    <= w_is_fill_d;
            r_prot_err   <= w_prot_err_d;
            if (r_state == StFill) begin
                r_fetch_buffer[r_beat_count*BEATW +: BEATW] <= r_mem[w_mem_idx];
            end
        end
    end

    // Storage is deliberately left out of reset so contents survive a reset pulse.
    always_ff @(posedge i_clk) begin
        if (r_state == StWb) begin
            r_mem[w_mem_idx] <= i_write_beat_data;
        end
    end

    assign o_beat_count    = r_beat_count;
    assign o_sel_bus_beat  = (r_state == StWb);
    assign o_fetch_buffer  = r_fetch_buffer;
    assign o_cache_bus_ack = w_ack;
    assign o_bus_busy      = (r_state != StIdle);
    assign o_prot_err      = r_prot_err;

endmodule
